// File: rtl/rs_syndrome_seq.sv
// Streaming RS(N,K) syndrome calculator: one symbol per accept, Horner update of every root in parallel; define RS_SYN_ERRCNT_EN for err_count.
// syn_valid rises the cycle after the N-th accept; results then hold with sym_ready low until syn_ready.
module rs_syndrome_seq #(
  parameter int             SYM_W     = 4,
  parameter int             N         = 15,
  parameter int             K         = 9,
  parameter logic [SYM_W:0] PRIM_POLY = 5'b10011,
  parameter int             FCR       = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SYM_W-1:0]         sym_in,
  input  logic                     sym_valid,
  output logic                     sym_ready,
  output logic [(N-K)*SYM_W-1:0]   syndromes,
  output logic                     error_detected,
  output logic                     syn_valid,
  input  logic                     syn_ready
`ifdef RS_SYN_ERRCNT_EN
  ,
  output logic [15:0]              err_count
`endif
);

  localparam int TWO_T = N - K;
  localparam int CNT_W = $clog2(N);

  typedef enum logic {ACCUM, HOLD} stateT;

  stateT            state, stateNext;
  logic [CNT_W-1:0] symCnt;
  logic [SYM_W-1:0] acc     [TWO_T];
  logic [SYM_W-1:0] accNext [TWO_T];
  logic             accept, synTake, lastSym;

  function automatic logic [SYM_W-1:0] mulAlpha(input logic [SYM_W-1:0] a);
    return {a[SYM_W-2:0], 1'b0} ^ (a[SYM_W-1] ? PRIM_POLY[SYM_W-1:0] : '0);
  endfunction

  function automatic logic [SYM_W-1:0] alphaPow(input int p);
    logic [SYM_W-1:0] v;
    v = SYM_W'(1);
    for (int k = 0; k < p; k++) v = mulAlpha(v);
    return v;
  endfunction

  // Shift-and-add multiply; with one operand constant this folds to a small XOR network.
  function automatic logic [SYM_W-1:0] gfMul(input logic [SYM_W-1:0] a, input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] prod, sh;
    prod = '0;
    sh   = a;
    for (int k = 0; k < SYM_W; k++) begin
      if (b[k]) prod = prod ^ sh;
      sh = mulAlpha(sh);
    end
    return prod;
  endfunction

  for (genvar i = 0; i < TWO_T; i++) begin : gRoot
    localparam logic [SYM_W-1:0] ROOT = alphaPow(FCR + i);
    assign accNext[i] = gfMul(acc[i], ROOT) ^ sym_in;
    assign syndromes[i*SYM_W +: SYM_W] = acc[i];
  end

  assign error_detected = |syndromes;
  assign lastSym        = (symCnt == CNT_W'(N - 1));
  assign accept         = sym_valid & sym_ready;
  assign synTake        = syn_valid & syn_ready;

  always_comb begin
    stateNext = state;
    sym_ready = 1'b0;
    syn_valid = 1'b0;
    case (state)
      ACCUM: begin
        sym_ready = rst_n;
        if (sym_valid && rst_n && lastSym) stateNext = HOLD;
      end
      HOLD: begin
        syn_valid = 1'b1;
        if (syn_ready) stateNext = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ACCUM;
      symCnt <= '0;
      for (int i = 0; i < TWO_T; i++) acc[i] <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        symCnt <= lastSym ? '0 : symCnt + 1'b1;
        for (int i = 0; i < TWO_T; i++) acc[i] <= accNext[i];
      end else if (synTake) begin
        // Clearing on the handshake lets the next word start Horner from zero.
        for (int i = 0; i < TWO_T; i++) acc[i] <= '0;
      end
    end
  end

`ifdef RS_SYN_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (synTake && error_detected && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rs_syndrome_seq.sv
// Bench for rs_syndrome_seq (defaults RS(15,9), GF(16), FCR=1): log/antilog reference model plus directed literal cases.
module tb_rs_syndrome_seq;

  localparam int N     = 15;
  localparam int TWO_T = 6;
  localparam int FCR   = 1;

  typedef logic [3:0] symQ[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sym_in;
  logic        sym_valid;
  logic        sym_ready;
  logic [23:0] syndromes;
  logic        error_detected;
  logic        syn_valid;
  logic        syn_ready;
`ifdef RS_SYN_ERRCNT_EN
  logic [15:0] err_count;
`endif

  rs_syndrome_seq dut (
    .clk(clk),
    .rst_n(rst_n),
    .sym_in(sym_in),
    .sym_valid(sym_valid),
    .sym_ready(sym_ready),
    .syndromes(syndromes),
    .error_detected(error_detected),
    .syn_valid(syn_valid),
    .syn_ready(syn_ready)
`ifdef RS_SYN_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int bad  = 0;
  int cyc  = 0;
  always @(posedge clk) cyc++;

  logic [3:0] expT [15];
  int         logT [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finishRun();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  endtask

  // r * alpha^e via log/antilog tables
  function automatic logic [3:0] mulPow(input logic [3:0] r, input int e);
    if (r == 4'h0) return 4'h0;
    return expT[(logT[r] + e) % 15];
  endfunction

  // S_(FCR+i) = sum_j r_j * alpha^((FCR+i)*j); w[0] holds r_(N-1)
  function automatic logic [23:0] refSyn(input symQ w);
    logic [23:0] s;
    logic [3:0]  a;
    s = '0;
    for (int i = 0; i < TWO_T; i++) begin
      a = 4'h0;
      for (int idx = 0; idx < w.size(); idx++) a = a ^ mulPow(w[idx], (FCR + i) * (N - 1 - idx));
      s[i*4 +: 4] = a;
    end
    return s;
  endfunction

  function automatic symQ zeroWord(input int deg, input logic [3:0] val);
    symQ w;
    w = {};
    for (int idx = 0; idx < N; idx++) w.push_back((idx == N - 1 - deg) ? val : 4'h0);
    return w;
  endfunction

  // Reference model and per-cycle compare
  symQ mWord;
  bit  mHold = 0;
  bit  armed = 0;
  int  mErr  = 0;

  always @(negedge clk) begin
    logic [23:0] expSyn;
    expSyn = '0;
    if (!rst_n) begin
      check("sym_ready_in_reset", sym_ready, 0);
      mWord = {};
      mHold = 0;
      mErr  = 0;
      armed = 1;
    end else if (armed) begin
      check("sym_ready", sym_ready, !mHold);
      check("syn_valid", syn_valid, mHold);
      if (mHold) begin
        expSyn = refSyn(mWord);
        check("syndromes", syndromes, expSyn);
        check("error_detected", error_detected, expSyn != 0);
      end
`ifdef RS_SYN_ERRCNT_EN
      check("err_count", err_count, mErr);
`endif
      if (mHold) begin
        if (syn_ready) begin
          if (expSyn != 0 && mErr < 65535) mErr++;
          mHold = 0;
          mWord = {};
        end
      end else if (sym_valid) begin
        mWord.push_back(sym_in);
        if (mWord.size() == N) mHold = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns at posedge+1 right after the last symbol was accepted.
  task automatic sendWord(input symQ w, input bit gaps, input int gapPct);
    bit took;
    int budget;
    for (int idx = 0; idx < w.size(); idx++) begin
      sym_in    = w[idx];
      sym_valid = 1'b1;
      took      = 0;
      budget    = 0;
      while (!took) begin
        @(negedge clk);
        took = sym_ready;
        tick();
        budget++;
        if (budget > 200) begin
          check("accept_timeout", 0, 1);
          finishRun();
        end
      end
      if (idx < w.size() - 1) begin
        if (gaps) begin
          sym_valid = 1'b0;
          tick();
        end
        while ($urandom_range(0, 99) < gapPct) begin
          sym_valid = 1'b0;
          tick();
        end
      end
    end
    sym_valid = 1'b0;
  endtask

  // Called right after the N-th accept; holds syn_ready low for 'hold' cycles.
  task automatic takeSyn(input int hold, output logic [23:0] got, output logic gotErr);
    check("syn_valid_latency", syn_valid, 1);
    got    = syndromes;
    gotErr = error_detected;
    syn_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_stable_syn", syndromes, got);
      check("hold_syn_valid", syn_valid, 1);
      check("hold_sym_ready", sym_ready, 0);
    end
    syn_ready = 1'b1;
    tick();
    syn_ready = 1'b0;
    check("sym_ready_after_take", sym_ready, 1);
    check("syn_valid_after_take", syn_valid, 0);
  endtask

  task automatic doReset();
    sym_valid = 1'b0;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    check("global_timeout", 0, 1);
    finishRun();
  end

  initial begin
    logic [3:0]  v;
    logic [23:0] got;
    logic        gotErr;
    symQ         w;
    int          c0;

    v = 4'h1;
    for (int e = 0; e < 15; e++) begin
      expT[e] = v;
      logT[v] = e;
      v = {v[2:0], 1'b0} ^ (v[3] ? 4'b0011 : 4'b0000);
    end
    logT[0] = 0;

    rst_n = 1'b0; sym_in = 4'h0; sym_valid = 1'b0; syn_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("reset_sym_ready", sym_ready, 1);
    check("reset_syn_valid", syn_valid, 0);
    check("reset_syndromes", syndromes, 0);
    check("reset_error", error_detected, 0);
`ifdef RS_SYN_ERRCNT_EN
    check("reset_err_count", err_count, 0);
`endif

    // Case 1: all zeros
    sendWord(zeroWord(0, 4'h0), 0, 0);
    takeSyn(0, got, gotErr);
    check("c1_syn", got, 24'h000000);
    check("c1_err", gotErr, 0);

    // Case 2: e=1 at r_0
    sendWord(zeroWord(0, 4'h1), 0, 0);
    takeSyn(0, got, gotErr);
    check("c2_syn", got, 24'h111111);
    check("c2_err", gotErr, 1);

    // Case 3: e=1 at r_1
    sendWord(zeroWord(1, 4'h1), 0, 0);
    takeSyn(0, got, gotErr);
    check("c3_syn", got, 24'hC63842);

    // Case 4: backpressure 5 cycles with next word's first symbol waiting
    sendWord(zeroWord(1, 4'h1), 0, 0);
    sym_in    = 4'h0;
    sym_valid = 1'b1;
    takeSyn(5, got, gotErr);
    check("c4_syn", got, 24'hC63842);
    tick();
    w = zeroWord(0, 4'h0);
    void'(w.pop_front());
    sendWord(w, 0, 0);
    takeSyn(0, got, gotErr);
    check("c4_next_syn", got, 24'h000000);

    // Case 5: toggling sym_valid
    c0 = cyc;
    sendWord(zeroWord(0, 4'h1), 1, 0);
    check("c5_cycles", cyc - c0, 29);
    takeSyn(0, got, gotErr);
    check("c5_syn", got, 24'h111111);

    // Case 6: reset mid-word then zeros
    w = {};
    for (int i = 0; i < 7; i++) w.push_back(4'hF);
    sendWord(w, 0, 0);
    doReset();
    sendWord(zeroWord(0, 4'h0), 0, 0);
    takeSyn(0, got, gotErr);
    check("c6_syn", got, 24'h000000);

    // Randomized words, gaps, backpressure and occasional mid-word reset
    for (int t = 0; t < 40; t++) begin
      w = {};
      case ($urandom_range(0, 2))
        0: for (int i = 0; i < N; i++) w.push_back(4'($urandom_range(0, 15)));
        1: begin
          w = zeroWord(0, 4'h0);
          for (int e = 0; e < 3; e++) w[$urandom_range(0, N - 1)] = 4'($urandom_range(1, 15));
        end
        default: w = zeroWord(0, 4'h0);
      endcase
      if ($urandom_range(0, 7) == 0) begin
        while (w.size() > 1 + $urandom_range(0, N - 3)) void'(w.pop_back());
        sendWord(w, 0, 30);
        doReset();
      end else begin
        sendWord(w, 0, $urandom_range(0, 50));
        takeSyn($urandom_range(0, 3), got, gotErr);
        check("rand_syn", got, refSyn(w));
      end
    end

`ifdef RS_SYN_ERRCNT_EN
    doReset();
    for (int r = 0; r < 3; r++) begin
      sendWord(zeroWord(0, 4'h1), 0, 0);
      takeSyn(0, got, gotErr);
    end
    check("errcnt_three", err_count, 3);
    sendWord(zeroWord(0, 4'h0), 0, 0);
    takeSyn(0, got, gotErr);
    check("errcnt_stays", err_count, 3);
`endif

    tick();
    finishRun();
  end

endmodule
